// File: rtl/gpio_display_if.sv
// Bundles the display driver's data/segment signals: the core side drives value/dec_mode,
// the driver returns eight segment digits plus status.
interface gpio_display_if;
   logic [31:0] value;
   logic        dec_mode;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic        busy;
   logic        overflow;

   modport master (
      output value, dec_mode,
      input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, overflow
   );

   modport slave (
      input  value, dec_mode,
      output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, overflow
   );
endinterface

// File: rtl/gpio_display_driver.sv
// Seven-segment driver for the CPU gpio_out word: registered hex or double-dabble decimal
// conversion, refreshed only when the shown value or mode is stale.
//
// state | meaning
// IDLE  | display current, compare input against shadow registers
// CONV  | one double-dabble step per cycle, 32 cycles
// LATCH | decode captured value into the segment registers
module gpio_display_driver #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic            clk,
   input logic            rst,
   gpio_display_if.slave  io
);
   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t      state, state_nxt;
   logic [31:0] shown_val, cap_val;
   logic        shown_mode, shown_ok, cap_mode;
   logic [39:0] bcd, bcd_adj, bcd_step;
   logic [4:0]  cnt;
   logic        start;
   logic [6:0]  hex_q [8];
   logic [6:0]  hex_nxt [8];
   logic        ovf_q, ovf_nxt;
   int          msd;

   localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [6:0] DASH  = ACTIVE_LOW ? 7'h3F : 7'h40;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
         4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
         4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
         4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
      endcase
      return ACTIVE_LOW ? ~g : g;
   endfunction

   assign start = !shown_ok || (io.value != shown_val) || (io.dec_mode != shown_mode);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = io.dec_mode ? CONV : LATCH;
         CONV:    if (cnt == 5'd31) state_nxt = LATCH;
         LATCH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 correction on every nibble, then shift in the next value bit MSB first.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 10; i++)
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      bcd_step = {bcd_adj[38:0], cap_val[~cnt]};
   end

   always_comb begin
      io.busy = (state != IDLE);
      ovf_nxt = 1'b0;
      msd     = 0;
      for (int i = 0; i < 8; i++)
         if (bcd[4*i +: 4] != 4'd0) msd = i;
      for (int i = 0; i < 8; i++)
         hex_nxt[i] = glyph(cap_val[4*i +: 4]);
      if (cap_mode) begin
         if (bcd[39:32] != 8'd0) begin
            ovf_nxt = 1'b1;
            for (int i = 0; i < 8; i++) hex_nxt[i] = DASH;
         end else begin
            for (int i = 0; i < 8; i++)
               hex_nxt[i] = (i > msd) ? BLANK : glyph(bcd[4*i +: 4]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shown_val  <= '0;
         shown_mode <= 1'b0;
         shown_ok   <= 1'b0;
         cap_val    <= '0;
         cap_mode   <= 1'b0;
         bcd        <= '0;
         cnt        <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < 8; i++) hex_q[i] <= BLANK;
      end else begin
         case (state)
            IDLE: if (start) begin
               cap_val  <= io.value;
               cap_mode <= io.dec_mode;
               bcd      <= '0;
               cnt      <= '0;
            end
            CONV: begin
               bcd <= bcd_step;
               cnt <= cnt + 5'd1;
            end
            LATCH: begin
               hex_q      <= hex_nxt;
               ovf_q      <= ovf_nxt;
               shown_val  <= cap_val;
               shown_mode <= cap_mode;
               shown_ok   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign io.hex0     = hex_q[0];
   assign io.hex1     = hex_q[1];
   assign io.hex2     = hex_q[2];
   assign io.hex3     = hex_q[3];
   assign io.hex4     = hex_q[4];
   assign io.hex5     = hex_q[5];
   assign io.hex6     = hex_q[6];
   assign io.hex7     = hex_q[7];
   assign io.overflow = ovf_q;
endmodule

// File: tb/tb_gpio_display_driver.sv
// Bench for gpio_display_driver: per-cycle comparison against a timing/arithmetic model,
// directed scenarios with literal expectations, then randomized values and modes.
module tb_gpio_display_driver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic chk_en = 1'b0;

   gpio_display_if dif ();

   gpio_display_driver #(.ACTIVE_LOW(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .io  (dif)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // {overflow, hex7..hex0} for an active-low board, computed arithmetically.
   function automatic logic [56:0] ref_disp(input logic [31:0] v, input logic m);
      logic [56:0] r;
      longint p;
      r = '0;
      if (!m) begin
         for (int i = 0; i < 8; i++) r[7*i +: 7] = ~seg(v[4*i +: 4]);
      end else if (v > 32'd99999999) begin
         r[56] = 1'b1;
         for (int i = 0; i < 8; i++) r[7*i +: 7] = 7'h3F;
      end else begin
         p = 1;
         for (int i = 0; i < 8; i++) begin
            if (i == 0 || longint'(v) >= p) r[7*i +: 7] = ~seg(4'((longint'(v) / p) % 10));
            else                            r[7*i +: 7] = 7'h7F;
            p = p * 10;
         end
      end
      return r;
   endfunction

   function automatic logic [55:0] dut_hex();
      return {dif.hex7, dif.hex6, dif.hex5, dif.hex4, dif.hex3, dif.hex2, dif.hex1, dif.hex0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a countdown of remaining busy cycles plus the last latched snapshot.
   int          rem = 0;
   logic [31:0] cv, sv;
   logic        cm, sm, sok;
   logic [55:0] e_hex;
   logic        e_ovf, e_busy;
   logic [56:0] r;

   always @(posedge clk) begin
      if (rst) begin
         rem = 0; sok = 1'b0; e_ovf = 1'b0; e_hex = {8{7'h7F}};
      end else if (rem == 0) begin
         if (!sok || dif.value != sv || dif.dec_mode != sm) begin
            cv = dif.value; cm = dif.dec_mode; rem = cm ? 33 : 1;
         end
      end else begin
         rem = rem - 1;
         if (rem == 0) begin
            r = ref_disp(cv, cm);
            e_hex = r[55:0]; e_ovf = r[56];
            sv = cv; sm = cm; sok = 1'b1;
         end
      end
      e_busy = (rem != 0);
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(dif.busy), 32'(e_busy));
         chk("overflow", 32'(dif.overflow), 32'(e_ovf));
         for (int i = 0; i < 8; i++)
            chk($sformatf("hex%0d", i), 32'(dut_hex() >> (7*i) & 56'h7F), 32'(e_hex >> (7*i) & 56'h7F));
      end
   end

   task automatic wait_idle(output int n);
      n = 0;
      @(negedge clk);
      while (dif.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic show(input logic [31:0] v, input logic m, output int n);
      dif.value = v; dif.dec_mode = m;
      wait_idle(n);
   endtask

   task automatic pin(input string nm, input logic [55:0] w, input logic o);
      chk({nm, "_digits"}, 32'(dut_hex() >> 28), 32'(w >> 28));
      chk({nm, "_digits_lo"}, 32'(dut_hex() & 56'hFFFFFFF), 32'(w & 56'hFFFFFFF));
      chk({nm, "_ovf"}, 32'(dif.overflow), 32'(o));
   endtask

   initial begin
      int n, k;
      logic [31:0] v;
      dif.value = 32'd0; dif.dec_mode = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_idle(n);
      chk("rst_busy_len", n, 33);
      pin("zero", {{7{7'h7F}}, 7'h40}, 1'b0);

      show(32'd12345678, 1'b1, n);
      chk("dec_busy_len", n, 33);
      pin("dec12345678", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0);

      show(32'hDEADBEEF, 1'b0, n);
      chk("hex_busy_len", n, 1);
      pin("deadbeef", {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0);
      show(32'hDEADBEEF, 1'b1, n);
      chk("dec_deadbeef_len", n, 33);
      pin("deadbeef_dec", {8{7'h3F}}, 1'b1);

      show(32'd99999999, 1'b1, n);
      pin("max8", {8{7'h10}}, 1'b0);
      show(32'd100000000, 1'b1, n);
      pin("ovf9", {8{7'h3F}}, 1'b1);

      dif.value = 32'd5;
      repeat (10) @(negedge clk);
      chk("mid_busy", 32'(dif.busy), 32'd1);
      dif.value = 32'd42;
      wait_idle(n);
      pin("five", {{7{7'h7F}}, 7'h12}, 1'b0);
      @(negedge clk);
      chk("rebusy", 32'(dif.busy), 32'd1);
      wait_idle(n);
      chk("rebusy_len", n, 32);
      pin("fortytwo", {{6{7'h7F}}, 7'h19, 7'h24}, 1'b0);

      dif.value = 32'd777;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(dif.busy), 32'd0);
      pin("abort", {8{7'h7F}}, 1'b0);
      rst = 1'b0;
      wait_idle(n);
      chk("after_rst_len", n, 33);
      pin("s777", {{5{7'h7F}}, 7'h78, 7'h78, 7'h78}, 1'b0);

      repeat (20) @(negedge clk);
      chk("stable_idle", 32'(dif.busy), 32'd0);

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 999);
            1: v = $urandom_range(0, 99999999);
            2: v = $urandom;
            default: v = ($urandom_range(0, 1) == 1) ? 32'd99999999 + $urandom_range(0, 2) : 32'd10000000 - $urandom_range(0, 1);
         endcase
         dif.value = v;
         dif.dec_mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(1, 30);
            repeat (k) @(negedge clk);
            dif.value = $urandom;
         end
         wait_idle(n);
         @(negedge clk);
         if (dif.busy) wait_idle(n);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
